// File: rtl/io_read_responder.sv
// io_read_responder: load-side responder for the memory-mapped region map.
// Decodes a load into data memory or an I/O register, waits out the memory
// latency, and returns one extended word per request. It also synchronises
// the switches and buttons and keeps read-to-clear sticky button presses.
module io_read_responder #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned SW_W    = 16,
    parameter int unsigned BTN_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [15:0]       rd_addr,
    input  logic [2:0]        rd_funct3,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              rd_err,
    output logic              mem_re,
    output logic [10:0]       mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic [31:0]       leds_q,
    input  logic [31:0]       seg_q,
    input  logic [31:0]       lcd_q,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [BTN_W-1:0]  btn_in
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEMWAIT,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         lane_q;
    logic [2:0]         f3_q;
    logic               mem_re_q;
    logic [10:0]        mem_addr_q;
    logic               rd_valid_q;
    logic [31:0]        rd_data_q;
    logic               rd_err_q;

    logic [SW_W-1:0]    sw_s1_q;
    logic [SW_W-1:0]    sw_s2_q;
    logic [BTN_W-1:0]   btn_s1_q;
    logic [BTN_W-1:0]   btn_s2_q;
    logic [BTN_W-1:0]   sticky_q;
    logic [BTN_W-1:0]   sticky_d;

    logic               in_mem;
    logic               is_led;
    logic               is_seg;
    logic               is_lcd;
    logic               is_sw;
    logic               is_btn;
    logic               f3_bad;
    logic               misalign;
    logic               req_err;
    logic               btn_clr;
    logic [31:0]        io_word;

    // Select lane and sign/zero-extend according to the load funct3.
    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {lane, 3'b000};
        b  = sh[7:0];
        h  = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = w;
            3'b100:  load_ext = {24'h000000, b};
            3'b101:  load_ext = {16'h0000, h};
            default: load_ext = 32'h0000_0000;
        endcase
    endfunction

    // Region decode, error classification, I/O source mux and sticky update.
    always_comb begin
        in_mem   = (rd_addr[15:11] == 5'b00001);
        is_led   = (rd_addr == 16'h1C00);
        is_seg   = (rd_addr == 16'h1C08) || (rd_addr == 16'h1C09);
        is_lcd   = (rd_addr == 16'h1C0C);
        is_sw    = (rd_addr == 16'h1E00);
        is_btn   = (rd_addr == 16'h1E04);
        f3_bad   = (rd_funct3 == 3'b011) || (rd_funct3[2:1] == 2'b11);
        misalign = ((rd_funct3[1:0] == 2'b01) && rd_addr[0]) ||
                   ((rd_funct3[1:0] == 2'b10) && (rd_addr[1:0] != 2'b00));
        req_err  = f3_bad || misalign ||
                   !(in_mem || is_led || is_seg || is_lcd || is_sw || is_btn);

        io_word = 32'h0000_0000;
        if (is_led) begin
            io_word = leds_q;
        end else if (is_seg) begin
            io_word = seg_q;
        end else if (is_lcd) begin
            io_word = lcd_q;
        end else if (is_sw) begin
            io_word = 32'(sw_s2_q);
        end else if (is_btn) begin
            io_word[BTN_W-1:0]     = btn_s2_q;
            io_word[BTN_W+15:16]   = sticky_q;
        end

        // A rise seen at the clearing edge survives the clear.
        btn_clr  = (state_q == S_IDLE) && rd_req && is_btn && !req_err;
        sticky_d = (btn_clr ? '0 : sticky_q) | (btn_s1_q & ~btn_s2_q);
    end

    // Input synchronisers and sticky press register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sticky_q <= '0;
        end else begin
            sw_s1_q  <= sw_in;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn_in;
            btn_s2_q <= btn_s1_q;
            sticky_q <= sticky_d;
        end
    end

    // Request FSM; the wait counter expires one edge after reaching zero so
    // the capture lands MEM_LAT edges after the memory samples mem_re.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lane_q     <= '0;
            f3_q       <= '0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            mem_re_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_req) begin
                        if (in_mem && !req_err) begin
                            lane_q     <= rd_addr[1:0];
                            f3_q       <= rd_funct3;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= rd_addr[10:0];
                            cnt_q      <= CNT_W'(MEM_LAT);
                            state_q    <= S_MEMWAIT;
                        end else begin
                            rd_data_q  <= req_err ? 32'h0000_0000
                                                  : load_ext(io_word, rd_addr[1:0], rd_funct3);
                            rd_err_q   <= req_err;
                            rd_valid_q <= 1'b1;
                            state_q    <= S_RESP;
                        end
                    end
                end
                S_MEMWAIT: begin
                    if (cnt_q == '0) begin
                        rd_data_q  <= load_ext(mem_rdata, lane_q, f3_q);
                        rd_err_q   <= 1'b0;
                        rd_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_ready = (state_q == S_IDLE) && !reset;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;
    assign mem_re   = mem_re_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_io_read_responder.sv
// Bench for io_read_responder: scoreboard of expected responses (data, error,
// cycle) checked by a negedge monitor, plus per-scenario tasks.
module tb_io_read_responder;

    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned SW_W    = 16;
    localparam int unsigned BTN_W   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [15:0]       rd_addr;
    logic [2:0]        rd_funct3;
    logic              rd_ready;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              rd_err;
    logic              mem_re;
    logic [10:0]       mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       leds_q;
    logic [31:0]       seg_q;
    logic [31:0]       lcd_q;
    logic [SW_W-1:0]   sw_in;
    logic [BTN_W-1:0]  btn_in;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          mem_exp_cyc = -1;
    logic [10:0] mem_exp_addr = '0;
    logic [31:0] mem_word = '0;

    io_read_responder #(.MEM_LAT(MEM_LAT), .SW_W(SW_W), .BTN_W(BTN_W)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_funct3(rd_funct3),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .leds_q(leds_q), .seg_q(seg_q), .lcd_q(lcd_q),
        .sw_in(sw_in), .btn_in(btn_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Data memory: samples mem_re, word valid for exactly one cycle after.
    always @(posedge clk) mem_rdata <= mem_re ? mem_word : 32'h5A5A_5A5A;

    // Monitor: memory strobe and response scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mem_re === 1'b1) begin
            checks++;
            if (mem_exp_cyc != cyc || mem_addr !== mem_exp_addr) begin
                failures++;
                $display("FAIL mem_re: cycle=%0d addr=%h, expected cycle=%0d addr=%h",
                         cyc, mem_addr, mem_exp_cyc, mem_exp_addr);
            end
            mem_exp_cyc = -1;
        end
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: cycle=%0d data=%h err=%b", cyc, rd_data, rd_err);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.data || rd_err !== e.err || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL response: data=%h err=%b cycle=%0d, expected data=%h err=%b cycle=%0d",
                             rd_data, rd_err, cyc, e.data, e.err, e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.cyc  = c;
        sb.push_back(x);
    endtask

    // Issue one load at the current negedge and wait for its response.
    task automatic do_read(input logic [15:0] a, input logic [2:0] f3,
                           input logic [31:0] d, input logic e, input bit is_mem);
        int n;
        n = 0;
        while (rd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rd_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: rd_ready=%b expected 1", rd_ready);
            return;
        end
        rd_req    = 1'b1;
        rd_addr   = a;
        rd_funct3 = f3;
        if (is_mem) begin
            mem_exp_cyc  = cyc + 1;
            mem_exp_addr = a[10:0];
        end
        push_exp(d, e, cyc + 1 + (is_mem ? 1 + int'(MEM_LAT) : 0));
        @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: addr=%h pending=%0d expected 0", a, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rd_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0 ||
            rd_err !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 11'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h err=%b re=%b maddr=%h, expected all 0",
                     rd_ready, rd_valid, rd_data, rd_err, mem_re, mem_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: rd_ready=%b expected 1", rd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_mem();
        mem_word = 32'hDEAD_BEEF;
        do_read(16'h0800, 3'b010, 32'hDEAD_BEEF, 1'b0, 1'b1);
        mem_word = 32'h8012_3456;
        do_read(16'h0803, 3'b000, 32'hFFFF_FF80, 1'b0, 1'b1);
        do_read(16'h0803, 3'b100, 32'h0000_0080, 1'b0, 1'b1);
        do_read(16'h0802, 3'b001, 32'hFFFF_8012, 1'b0, 1'b1);
        do_read(16'h0802, 3'b101, 32'h0000_8012, 1'b0, 1'b1);
        do_read(16'h0FFD, 3'b000, 32'h0000_0034, 1'b0, 1'b1);
    endtask

    task automatic test_io();
        leds_q = 32'h0000_00A5;
        seg_q  = 32'h0000_C300;
        lcd_q  = 32'h1234_8765;
        do_read(16'h1C00, 3'b010, 32'h0000_00A5, 1'b0, 1'b0);
        do_read(16'h1C09, 3'b000, 32'hFFFF_FFC3, 1'b0, 1'b0);
        do_read(16'h1C0C, 3'b001, 32'hFFFF_8765, 1'b0, 1'b0);
        do_read(16'h1C0C, 3'b101, 32'h0000_8765, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        mem_word = 32'hFFFF_FFFF;
        do_read(16'h1000, 3'b010, 32'h0, 1'b1, 1'b0);
        do_read(16'h1C01, 3'b001, 32'h0, 1'b1, 1'b0);
        do_read(16'h0800, 3'b011, 32'h0, 1'b1, 1'b0);
        do_read(16'h0802, 3'b010, 32'h0, 1'b1, 1'b0);
        do_read(16'h0800, 3'b110, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int c;
        int n;
        leds_q    = 32'h0000_0077;
        c         = cyc;
        rd_req    = 1'b1;
        rd_addr   = 16'h1C00;
        rd_funct3 = 3'b010;
        push_exp(32'h0000_0077, 1'b0, c + 1);
        push_exp(32'h0000_0077, 1'b0, c + 3);
        repeat (3) @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL b2b_timeout: pending=%0d expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_memwait();
        do_read(16'h1C00, 3'b010, 32'h0000_0077, 1'b0, 1'b0);
        mem_word     = 32'h1111_1111;
        rd_req       = 1'b1;
        rd_addr      = 16'h0844;
        rd_funct3    = 3'b010;
        mem_exp_cyc  = cyc + 1;
        mem_exp_addr = 11'h044;
        @(negedge clk);
        rd_req = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0 ||
            rd_err !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 11'h0) begin
            failures++;
            $display("FAIL reset_abort: ready=%b valid=%b data=%h err=%b re=%b maddr=%h, expected all 0",
                     rd_ready, rd_valid, rd_data, rd_err, mem_re, mem_addr);
        end
        sw_in = 16'h00FF;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_abort: rd_ready=%b expected 1", rd_ready);
        end
        repeat (5) @(negedge clk);
        do_read(16'h1E00, 3'b010, 32'h0000_00FF, 1'b0, 1'b0);
        // Change lands one edge before capture: still the old value.
        sw_in = 16'h1234;
        do_read(16'h1E00, 3'b010, 32'h0000_00FF, 1'b0, 1'b0);
        do_read(16'h1E00, 3'b010, 32'h0000_1234, 1'b0, 1'b0);
    endtask

    task automatic test_sticky();
        btn_in = '0;
        repeat (3) @(negedge clk);
        btn_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        btn_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        do_read(16'h1E04, 3'b010, 32'h0004_0000, 1'b0, 1'b0);
        // Rise reaches the synchronised level on the clearing edge.
        btn_in[2] = 1'b1;
        @(negedge clk);
        do_read(16'h1E04, 3'b010, 32'h0000_0000, 1'b0, 1'b0);
        do_read(16'h1E04, 3'b010, 32'h0004_0004, 1'b0, 1'b0);
        btn_in[2] = 1'b0;
        btn_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        btn_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        do_read(16'h1E05, 3'b001, 32'h0, 1'b1, 1'b0);
        do_read(16'h1E04, 3'b010, 32'h0002_0000, 1'b0, 1'b0);
        do_read(16'h1E04, 3'b010, 32'h0000_0000, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        rd_req    = 1'b0;
        rd_addr   = '0;
        rd_funct3 = '0;
        leds_q    = '0;
        seg_q     = '0;
        lcd_q     = '0;
        sw_in     = '0;
        btn_in    = '0;
        test_reset();
        test_mem();
        test_io();
        test_errors();
        test_back_to_back();
        test_reset_memwait();
        test_sticky();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_read_responder.md
# io_read_responder

Read-side counterpart of the memory-mapped address decoder. It accepts load requests from the RISC-V core's memory stage, selects the addressed region (data memory or an I/O register), and waits for the data-memory read latency. It returns one sign- or zero-extended word per request with a valid pulse. It also synchronises the switch and button inputs and holds a read-to-clear sticky register of button presses.

## Interface
- MEM_LAT, 1: data-memory read latency in cycles, from the `mem_re` sample edge to the edge where `mem_rdata` is valid; range 1–4.
- SW_W, 16: switch count.
- BTN_W, 4: button count.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  load request; sampled only while rd_ready=1
- rd_addr  in  16  byte address
- rd_funct3  in  3  RISC-V load funct3
- rd_ready  out  1  high in IDLE; low while reset is asserted
- rd_valid  out  1  one-cycle response strobe
- rd_data  out  32  extended load result
- rd_err  out  1  qualifies rd_valid: unmapped address, illegal funct3 or misaligned access
- mem_re  out  1  data-memory read enable, one cycle
- mem_addr  out  11  data-memory byte address (rd_addr[10:0])
- mem_rdata  in  32  data-memory read word
- leds_q, seg_q, lcd_q  in  32 each  readback of the LED, 7-segment and LCD registers
- sw_in  in  SW_W  asynchronous switches
- btn_in  in  BTN_W  asynchronous buttons

## Operation
- Region decode at acceptance:
  - MEM: 0x0800–0x0FFF
  - LED: 0x1C00
  - SEG: 0x1C08–0x1C09, word 0x1C08
  - LCD: 0x1C0C
  - SW: 0x1E00
  - BTN: 0x1E04
  - Anything else is unmapped.
- Source word:
  - Mapped regions return mem_rdata, leds_q, seg_q or lcd_q.
  - SW returns the zero-extended synchronised switches.
  - BTN returns the synchronised button levels in bits [BTN_W-1:0] and the sticky press bits in [BTN_W+15:16]; all other bits are 0.
- Lane select and extension:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - funct3 000 lb (sign-extend), 001 lh (sign-extend), 010 lw, 100 lbu (zero-extend), 101 lhu (zero-extend).
- Error cases:
  - funct3 011, 110 or 111; lh/lhu with addr[0]=1; lw with addr[1:0]≠0; any unmapped address.
  - Each error gives rd_err=1 and rd_data=0.
  - An errored request never asserts mem_re and never clears sticky bits.
- FSM states: IDLE, MEMWAIT, RESP.
  - IDLE, rd_req=1, MEM region, no error: latch addr and funct3, set mem_re=1 for the next cycle, load the wait counter with MEM_LAT, go to MEMWAIT.
  - IDLE, rd_req=1, any other case: capture the extended result (or the error) at this edge, go to RESP.
  - MEMWAIT: decrement the counter each cycle. At the edge where the counter reaches 0, capture the extended mem_rdata and go to RESP.
  - RESP: rd_valid=1 for one cycle, then IDLE; rd_ready=0 throughout.
  - rd_req outside IDLE is ignored; there is no queueing.
- Synchronisers: two flops per switch/button bit, always running, cleared by reset.
- Sticky register: a 0→1 transition of a synchronised button sets its bit.
  - A successful BTN read clears all sticky bits at its capture edge.
  - A rising edge at that same edge wins, so that bit stays 1.
- rd_data and rd_err hold their values until the next capture.

## Timing
- Reset (synchronous) forces:
  - state IDLE, rd_valid=0, rd_err=0, rd_data=0, mem_re=0, mem_addr=0
  - sticky bits 0, synchroniser flops 0, rd_ready=0 during reset
- Reset asserted in any state aborts the access: no rd_valid is produced and no sticky bits are cleared. rd_ready=1 in the first cycle after reset deasserts.
- I/O and error latency, with the request accepted at edge k: rd_valid is high in the cycle after edge k. Back-to-back requests complete at most one every 2 cycles.
- MEM latency:
  - mem_re and mem_addr are valid in the cycle after edge k.
  - The memory samples at edge k+1.
  - The capture happens at edge k+1+MEM_LAT; rd_valid is high in the following cycle.
- Input latency: a button or switch change becomes visible 2 edges after the input changes.

## Test plan
- lw 0x0800 with mem_rdata=0xDEADBEEF, MEM_LAT=1 -> mem_re=1 for one cycle with mem_addr=0x000; rd_valid in the cycle after edge k+2; rd_data=0xDEADBEEF; rd_err=0.
- lb 0x0803 with mem_rdata=0x80123456 -> 0xFFFFFF80; lbu -> 0x00000080; lh 0x0802 -> 0xFFFF8012; lhu 0x0802 -> 0x00008012.
- lw 0x1C00 with leds_q=0x000000A5 -> rd_valid in the cycle after acceptance, rd_data=0x000000A5; lb 0x1C09 with seg_q=0x0000C300 -> 0xFFFFFFC3.
- btn_in[2] high for 3 cycles then low; lw 0x1E04 -> rd_data=0x00040000. A second read -> 0x00000000. A rise landing on the clearing edge of the second read -> bit 18 is set on the third read.
- lw 0x1000 -> rd_err=1, rd_data=0; lh 0x1C01 -> rd_err=1; funct3=011 at 0x0800 -> rd_err=1 and mem_re is never asserted.
- reset pulsed during MEMWAIT -> no rd_valid; all outputs at reset values; rd_ready=1 in the first cycle after reset deasserts; a new lw 0x1E00 with sw_in=0x00FF held for 2 cycles beforehand -> rd_data=0x000000FF.
